// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory stage: access FSM states, func3 width codes, store lane helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef struct packed {
    logic [3:0] byteen;
    word_t      data;
  } store_lane_t;

  // Byte/half stores replicate the value so the dcache can pick any lane by byteen.
  function automatic store_lane_t store_format(logic [2:0] func3, logic [1:0] addr_lo, word_t data);
    store_lane_t s;
    unique case (func3[1:0])
      2'b00: begin
        s.byteen = 4'b0001 << addr_lo;
        s.data   = {4{data[7:0]}};
      end
      2'b01: begin
        s.byteen = 4'b0011 << {addr_lo[1], 1'b0};
        s.data   = {2{data[15:0]}};
      end
      default: begin
        s.byteen = 4'hF;
        s.data   = data;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// load_align: selects the addressed byte/half of a dcache word and sign- or zero-extends it.
module load_align
  import cpu_types_pkg::*;
(
  input  word_t       dmemload,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output word_t       load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = dmemload[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? dmemload[31:16] : dmemload[15:0];
    load_data = dmemload;
    case (func3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'd0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'd0, half_sel};
      default: load_data = dmemload;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer between EX/MEM, the dcache and MEM/WB.
// Optional LR/SC reservation support is compiled in with ATOMIC_RESERVATION_EN.
module mem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  input  logic        wb_stall,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic [3:0]  dmembyteen,
  output logic [31:0] load_data,
  output logic        mem_busy,
  output logic        wb_en,
  output logic        misalign,
  output logic        mem_err
`ifdef ATOMIC_RESERVATION_EN
  ,
  input  logic        is_lr,
  input  logic        is_sc,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr
`endif
);

  // Last count value before the wait budget of 2**TIMEOUT_W-1 cycles runs out.
  localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  mem_state_t           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 flush_q, flush_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic [2:0]           func3_q, func3_d;
  logic                 ren_d, wen_d;
  word_t                daddr_d, dstore_d, load_d;
  logic [3:0]           byteen_d;
  logic                 misalign_d, err_d;

  logic        mem_op, start, misaligned, sc_fail, sc_q, sc_d;
  word_t       fmt_data;
  store_lane_t st_fmt;

  assign mem_op = memRead | memWrite;
  assign start  = req_valid & mem_op & ~flush;
  assign st_fmt = store_format(func3, addr[1:0], store_data);

  always_comb begin
    misaligned = 1'b0;
    unique case (func3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      default: misaligned = addr[1:0] != 2'b00;
    endcase
  end

  load_align u_load_align (
    .dmemload  (dmemload),
    .addr_lo   (addr_lo_q),
    .func3     (func3_q),
    .load_data (fmt_data)
  );

`ifdef ATOMIC_RESERVATION_EN
  logic        resv_valid_q, resv_valid_d;
  logic [29:0] resv_addr_q, resv_addr_d;

  assign sc_fail = is_sc & ~(resv_valid_q & (resv_addr_q == addr[31:2]));

  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    if (state_q == IDLE && start && !misaligned && is_lr && !is_sc) begin
      resv_valid_d = 1'b1;
      resv_addr_d  = addr[31:2];
    end
    if (state_q == IDLE && start && is_sc) begin
      resv_valid_d = 1'b0;
    end
    // Snoop is checked against the post-update address so it also beats a same-cycle LR.
    if (snoop_inv && snoop_addr[31:2] == resv_addr_d) begin
      resv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end
`else
  assign sc_fail = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    addr_lo_d  = addr_lo_q;
    func3_d    = func3_q;
    sc_d       = sc_q;
    ren_d      = dmemREN;
    wen_d      = dmemWEN;
    daddr_d    = dmemaddr;
    dstore_d   = dmemstore;
    byteen_d   = dmembyteen;
    load_d     = load_data;
    misalign_d = 1'b0;
    err_d      = mem_err;
    wb_en      = 1'b0;
    mem_busy   = 1'b0;

    unique case (state_q)
      IDLE: begin
        mem_busy = req_valid & (mem_op | wb_stall);
        if (req_valid && !mem_op && !flush) begin
          wb_en = ~wb_stall;
        end
        if (start) begin
          if (misaligned) begin
            misalign_d = 1'b1;
            load_d     = '0;
            state_d    = DONE;
          end else if (sc_fail) begin
            load_d  = 32'd1;
            state_d = DONE;
          end else begin
            state_d   = ACCESS;
            cnt_d     = '0;
            flush_d   = 1'b0;
            addr_lo_d = addr[1:0];
            func3_d   = func3;
`ifdef ATOMIC_RESERVATION_EN
            sc_d      = is_sc;
`else
            sc_d      = 1'b0;
`endif
            ren_d     = ~memWrite;
            wen_d     = memWrite;
            daddr_d   = {addr[31:2], 2'b00};
            dstore_d  = memWrite ? st_fmt.data : '0;
            byteen_d  = memWrite ? st_fmt.byteen : 4'h0;
          end
        end
      end
      ACCESS: begin
        mem_busy = 1'b1;
        flush_d  = flush_q | flush;
        // A flushed access still runs to completion; only its writeback is suppressed.
        if (dhit) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          load_d  = sc_q ? '0 : fmt_data;
          state_d = (flush_q | flush) ? IDLE : DONE;
        end else if (cnt_q == CntLast) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          err_d   = 1'b1;
          load_d  = '0;
          state_d = (flush_q | flush) ? IDLE : DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        mem_busy = wb_stall;
        if (flush) begin
          state_d = IDLE;
        end else begin
          wb_en = ~wb_stall;
          if (!wb_stall) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      addr_lo_q  <= 2'b00;
      func3_q    <= 3'b000;
      sc_q       <= 1'b0;
      dmemREN    <= 1'b0;
      dmemWEN    <= 1'b0;
      dmemaddr   <= '0;
      dmemstore  <= '0;
      dmembyteen <= 4'h0;
      load_data  <= '0;
      misalign   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      addr_lo_q  <= addr_lo_d;
      func3_q    <= func3_d;
      sc_q       <= sc_d;
      dmemREN    <= ren_d;
      dmemWEN    <= wen_d;
      dmemaddr   <= daddr_d;
      dmemstore  <= dstore_d;
      dmembyteen <= byteen_d;
      load_data  <= load_d;
      misalign   <= misalign_d;
      mem_err    <= err_d;
    end
  end

endmodule
